neuron_seq: RTL and testbench
=============================

# neuron_seq

Sequencing controller for the team's weighted-sum-and-threshold neuron datapath. The block stores one signed weight per input and a firing threshold, loaded through a config port. On `start` it accepts `N_INPUTS` unsigned samples over a valid/ready stream and accumulates their weighted sum, with saturation. It then compares the sum against the threshold and presents `fire` and the sum on a held output handshake. It sits between the top-level pin wrapper (which drives config and samples from `ui_in`/`uio_in`) and the `uo_out` fire/sum pins.

## Interface
- `N_INPUTS`, 4: number of samples per evaluation, range 2..8.
- `DATA_W`, 4: unsigned sample width.
- `WEIGHT_W`, 4: signed two's-complement weight width.
- `ACC_W`, 12: signed accumulator, threshold and sum width.
- `clk` in 1: the only clock.
- `rst_n` in 1: asynchronous active-low reset.
- `cfg_we` in 1: config write strobe.
- `cfg_addr` in 4: 0..N_INPUTS-1 selects a weight; N_INPUTS selects the threshold.
- `cfg_data` in ACC_W: write data. The low WEIGHT_W bits are used for weights.
- `cfg_err` out 1: one-cycle pulse when a config write is dropped.
- `start` in 1: begin an evaluation. Sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `in_valid` in 1 / `in_data` in DATA_W / `in_ready` out 1: sample stream.
- `out_valid` out 1 / `out_ready` in 1: result handshake.
- `fire` out 1: result is sum >= threshold.
- `sum` out ACC_W: saturated weighted sum.

## Operation
- Reset values:
  - FSM in IDLE.
  - All weights = +1; threshold = +1.
  - accumulator = 0; index = 0.
  - `busy`, `in_ready`, `out_valid`, `fire`, `cfg_err` = 0; `sum` = 0.
- FSM states: IDLE, ACCUM, COMPARE, DONE.
- IDLE:
  - `cfg_we` with a valid address writes the register at the next clock edge.
  - `start` clears the accumulator and index, then moves to ACCUM.
  - If `start` and `cfg_we` occur in the same cycle, the write still commits. The evaluation uses the new value.
- ACCUM:
  - `in_ready` = 1.
  - Each beat (`in_valid & in_ready`): acc <= sat(acc + w[index] * in_data), then index++.
  - Product is signed WEIGHT_W+DATA_W+1 bits, sign-extended to ACC_W.
  - Saturation bounds are -2^(ACC_W-1) and 2^(ACC_W-1)-1.
  - After beat N_INPUTS-1, move to COMPARE.
  - Cycles without `in_valid` stall with no state change.
- COMPARE: register `fire` = (acc >= threshold), signed compare, and `sum` = acc. Move to DONE.
- DONE:
  - `out_valid` = 1; `fire` and `sum` are held stable.
  - On `out_ready`, move to IDLE and drop `out_valid`.
  - `fire` and `sum` keep their last value in IDLE until the next COMPARE.
- Dropped config writes:
  - A write outside IDLE, or with `cfg_addr` > N_INPUTS, is dropped.
  - `cfg_err` pulses the following cycle.
  - Stored registers are unchanged.
- `start` outside IDLE is ignored with no error.
- Reset mid-operation: the evaluation is aborted and everything returns to reset values, including the weights and threshold.

## Timing
- All outputs are registered except `in_ready` and `busy`, which decode the FSM state register.
- Latency with `start` at edge 0 and `in_valid` held high:
  - ACCUM covers cycles 1..N_INPUTS.
  - COMPARE is cycle N_INPUTS+1.
  - `out_valid` rises at cycle N_INPUTS+2.
  - With defaults this is cycle 6.
- With `out_ready` held high, DONE lasts one cycle and the next `start` is accepted in the cycle after.
- `out_ready` is only sampled in DONE.
- No combinational path from `in_valid` to `in_ready`.

## Structure
- Package `neuron_pkg` holds:
  - the FSM state enum (`st_idle`, `st_accum`, `st_compare`, `st_done`);
  - default widths;
  - reset constants for weight and threshold;
  - the threshold address offset (= N_INPUTS).
- Sub-module `neuron_mac`:
  - combinational signed multiply, add and saturate;
  - inputs acc, weight, sample; output next acc.
- FSM, register file and handshakes live in `neuron_seq`.

## Test plan
- Defaults:
  - Stimulus: reset, `start`, samples 1,1,1,1, `out_ready` = 1.
  - Expected: `sum` = 4, `fire` = 1, `out_valid` at cycle 6.
- All-zero input:
  - Stimulus: samples 0,0,0,0.
  - Expected: `sum` = 0, `fire` = 0.
- Signed weights:
  - Stimulus: weights = -8,7,0,1; threshold = 50; samples 15,15,3,9.
  - Expected: `sum` = -120+105+0+9 = -6, `fire` = 0.
- Saturation:
  - Stimulus: `ACC_W` = 8, all weights = 7, samples = 15.
  - Expected: `sum` clamps to 127 and stays there; `fire` = 1.
- Backpressure and stall:
  - Stimulus: `in_valid` gaps of 3 cycles; `out_ready` low for 5 cycles.
  - Expected: result unchanged; `out_valid`, `fire` and `sum` stable while held; `start` ignored while busy.
- Config error and reset:
  - Stimulus: `cfg_we` during ACCUM, and `cfg_addr` = 15 in IDLE.
  - Expected: `cfg_err` pulses once per write and stored values are unchanged.
  - Stimulus: assert `rst_n` low in ACCUM.
  - Expected: immediate IDLE, `busy` = 0, weights back to +1.

Source files
------------

// File: rtl/neuron_pkg.sv
`default_nettype none
// ============================================================================
// Module      : neuron_pkg
// Description : Shared FSM state type, default widths and reset constants
//               for the weighted-sum-and-threshold neuron sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package neuron_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        st_idle    = 2'd0,
        st_accum   = 2'd1,
        st_compare = 2'd2,
        st_done    = 2'd3
    } state_t;

    // Default widths
    localparam int c_n_inputs = 4;
    localparam int c_data_w   = 4;
    localparam int c_weight_w = 4;
    localparam int c_acc_w    = 12;

    // Reset values for the weight and threshold registers
    localparam int c_weight_rst = 1;
    localparam int c_thresh_rst = 1;

    // The threshold register sits one address past the last weight
    localparam int c_thr_addr_offset = c_n_inputs;

    // Threshold config address for a given number of inputs
    function automatic logic [3:0] thr_addr(input int n_inputs);
        return 4'(n_inputs);
    endfunction

endpackage
`default_nettype wire

// File: rtl/neuron_mac.sv
`default_nettype none
// ============================================================================
// Module      : neuron_mac
// Description : Combinational signed multiply-accumulate with saturation.
//               acc_next = sat(acc + weight * sample), sample is unsigned.
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_mac #(
    parameter int DATA_W   = 4,
    parameter int WEIGHT_W = 4,
    parameter int ACC_W    = 12
) (
    input  logic signed [ACC_W-1:0]    acc,
    input  logic signed [WEIGHT_W-1:0] weight,
    input  logic        [DATA_W-1:0]   sample,
    output logic signed [ACC_W-1:0]    acc_next
);

    // Product is wide enough for the unsigned sample to carry a zero sign bit
    localparam int PROD_W = WEIGHT_W + DATA_W + 1;
    // Sum width covers both operands plus one carry bit so overflow is visible
    localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

    localparam logic signed [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [PROD_W-1:0] w_weight_ext;
    logic signed [PROD_W-1:0] w_sample_ext;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [SUM_W-1:0]  w_sum;

    assign w_weight_ext = PROD_W'(weight);
    assign w_sample_ext = PROD_W'($signed({1'b0, sample}));
    assign w_prod       = w_weight_ext * w_sample_ext;
    assign w_sum        = SUM_W'(acc) + SUM_W'(w_prod);

    // Clamp the wide sum into the accumulator range
    always_comb begin
        acc_next = w_sum[ACC_W-1:0];
        if (w_sum > SUM_W'(c_acc_max)) begin
            acc_next = c_acc_max;
        end else if (w_sum < SUM_W'(c_acc_min)) begin
            acc_next = c_acc_min;
        end
    end

endmodule
`default_nettype wire

// File: rtl/neuron_seq.sv
`default_nettype none
// ============================================================================
// Module      : neuron_seq
// Description : Sequencer for the weighted-sum-and-threshold neuron. Holds
//               the weight/threshold register file, streams N_INPUTS samples
//               through the MAC and presents fire/sum on a held handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_seq
    import neuron_pkg::*;
#(
    parameter int N_INPUTS = c_n_inputs,
    parameter int DATA_W   = c_data_w,
    parameter int WEIGHT_W = c_weight_w,
    parameter int ACC_W    = c_acc_w
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_addr,
    input  logic [ACC_W-1:0]  cfg_data,
    output logic              cfg_err,
    input  logic              start,
    output logic              busy,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              fire,
    output logic [ACC_W-1:0]  sum
);

    localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [3:0] c_thr_addr = thr_addr(N_INPUTS);

    state_t                     r_state;
    state_t                     w_state_next;
    logic signed [WEIGHT_W-1:0] r_weight [N_INPUTS];
    logic signed [ACC_W-1:0]    r_threshold;
    logic signed [ACC_W-1:0]    r_acc;
    logic signed [ACC_W-1:0]    r_sum;
    logic signed [ACC_W-1:0]    w_acc_next;
    logic [IDX_W-1:0]           r_index;
    logic                       r_fire;
    logic                       r_out_valid;
    logic                       r_cfg_err;
    logic                       w_beat;
    logic                       w_last_beat;
    logic                       w_cfg_addr_ok;
    logic                       w_cfg_write;
    logic signed [WEIGHT_W-1:0] w_weight_sel;

    assign w_beat        = (r_state == st_accum) && in_valid;
    assign w_last_beat   = w_beat && (r_index == IDX_W'(N_INPUTS - 1));
    assign w_cfg_addr_ok = (cfg_addr <= c_thr_addr);
    assign w_cfg_write   = cfg_we && (r_state == st_idle) && w_cfg_addr_ok;
    assign w_weight_sel  = r_weight[r_index];

    assign busy      = (r_state != st_idle);
    assign in_ready  = (r_state == st_accum);
    assign out_valid = r_out_valid;
    assign fire      = r_fire;
    assign sum       = r_sum;
    assign cfg_err   = r_cfg_err;

    neuron_mac #(
        .DATA_W   (DATA_W),
        .WEIGHT_W (WEIGHT_W),
        .ACC_W    (ACC_W)
    ) u_mac (
        .acc      (r_acc),
        .weight   (w_weight_sel),
        .sample   (in_data),
        .acc_next (w_acc_next)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            st_idle:    if (start)       w_state_next = st_accum;
            st_accum:   if (w_last_beat) w_state_next = st_compare;
            st_compare:                  w_state_next = st_done;
            st_done:    if (out_ready)   w_state_next = st_idle;
            default:                     w_state_next = st_idle;
        endcase
    end

    // Weight and threshold register file, writable only while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                r_weight[i] <= WEIGHT_W'(c_weight_rst);
            end
            r_threshold <= ACC_W'(c_thresh_rst);
        end else if (w_cfg_write) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                if (cfg_addr == 4'(i)) begin
                    r_weight[i] <= cfg_data[WEIGHT_W-1:0];
                end
            end
            if (cfg_addr == c_thr_addr) begin
                r_threshold <= cfg_data;
            end
        end
    end

    // Flag any write that arrives while busy or targets an unmapped address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we && ((r_state != st_idle) || !w_cfg_addr_ok);
        end
    end

    // Accumulate, compare and hold the result until it is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_index     <= '0;
            r_fire      <= 1'b0;
            r_sum       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                st_idle: begin
                    if (start) begin
                        r_acc   <= '0;
                        r_index <= '0;
                    end
                end
                st_accum: begin
                    if (w_beat) begin
                        r_acc   <= w_acc_next;
                        r_index <= r_index + IDX_W'(1);
                    end
                end
                st_compare: begin
                    r_fire      <= (r_acc >= r_threshold);
                    r_sum       <= r_acc;
                    r_out_valid <= 1'b1;
                end
                st_done: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_neuron_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_neuron_seq
// Description : Self-checking bench for neuron_seq. Expected results come
//               from a behavioural model and are queued at stimulus time,
//               then compared when the result handshake completes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_seq;

    localparam int N = 4;

    typedef struct {
        int sum;
        bit fire;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [11:0] cfg_data = '0;
    logic        cfg_err;
    logic        start = 1'b0;
    logic        busy;
    logic        in_valid = 1'b0;
    logic [3:0]  in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        fire;
    logic [11:0] sum;

    logic        s8_cfg_we = 1'b0;
    logic [3:0]  s8_cfg_addr = '0;
    logic [7:0]  s8_cfg_data = '0;
    logic        s8_cfg_err;
    logic        s8_start = 1'b0;
    logic        s8_busy;
    logic        s8_in_valid = 1'b0;
    logic [3:0]  s8_in_data = '0;
    logic        s8_in_ready;
    logic        s8_out_valid;
    logic        s8_fire;
    logic [7:0]  s8_sum;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t sb_head;
    int   sh_w[N];
    int   sh_thr;
    int   held_sum;
    bit   held_fire;
    bit   hold_prev = 1'b0;

    always #5 clk = ~clk;

    neuron_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_err   (cfg_err),
        .start     (start),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fire      (fire),
        .sum       (sum)
    );

    neuron_seq #(.N_INPUTS(4), .DATA_W(4), .WEIGHT_W(4), .ACC_W(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (s8_cfg_we),
        .cfg_addr  (s8_cfg_addr),
        .cfg_data  (s8_cfg_data),
        .cfg_err   (s8_cfg_err),
        .start     (s8_start),
        .busy      (s8_busy),
        .in_valid  (s8_in_valid),
        .in_data   (s8_in_data),
        .in_ready  (s8_in_ready),
        .out_valid (s8_out_valid),
        .out_ready (1'b1),
        .fire      (s8_fire),
        .sum       (s8_sum)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Saturating weighted sum in plain integer arithmetic
    function automatic exp_t model(input int w[N], input int x[N], input int thr, input int accw);
        int   lo = -(1 << (accw - 1));
        int   hi = (1 << (accw - 1)) - 1;
        int   a = 0;
        exp_t e;
        for (int i = 0; i < N; i++) begin
            a = a + w[i] * x[i];
            if (a > hi) a = hi;
            if (a < lo) a = lo;
        end
        e.sum  = a;
        e.fire = (a >= thr);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shadow_reset();
        for (int i = 0; i < N; i++) sh_w[i] = 1;
        sh_thr = 1;
    endtask

    task automatic shadow_write(input logic [3:0] a, input logic [11:0] d);
        logic [3:0] lo4;
        lo4 = d[3:0];
        if (a < 4'(N)) sh_w[a] = int'($signed(lo4));
        else           sh_thr = int'($signed(d));
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [11:0] d, input bit exp_err);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we = 1'b0;
        check("cfg_err_pulse", cfg_err, exp_err);
        if (!exp_err) shadow_write(a, d);
        tick();
        check("cfg_err_clear", cfg_err, 0);
    endtask

    task automatic start_eval();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic feed(input int x[N], input int gap, input bit poke);
        int t;
        for (int i = 0; i < N; i++) begin
            for (int g = 0; g < gap; g++) begin
                start = poke;
                tick();
            end
            start = 1'b0;
            in_valid = 1'b1;
            in_data = 4'(x[i]);
            t = 0;
            while (!in_ready && t < 20) begin
                tick();
                t++;
            end
            if (t == 20) check("in_ready_timeout", in_ready, 1);
            tick();
            in_valid = 1'b0;
        end
    endtask

    // Wait for the result; optionally hold it back for five cycles
    task automatic finish(input bit hold);
        int t = 0;
        if (hold) out_ready = 1'b0;
        while (!out_valid && t < 40) begin
            tick();
            t++;
        end
        if (t == 40) check("out_valid_timeout", out_valid, 1);
        if (hold) begin
            start = 1'b1;
            repeat (5) tick();
            start = 1'b0;
            out_ready = 1'b1;
        end
        tick();
        check("idle_after_result", busy, 0);
        check("valid_dropped", out_valid, 0);
    endtask

    task automatic run(input int x[N], input int gap, input bit poke, input bit hold);
        sb.push_back(model(sh_w, x, sh_thr, 12));
        start_eval();
        feed(x, gap, poke);
        finish(hold);
    endtask

    task automatic sat_run(input logic [7:0] wdata, input int wval, input string tag);
        int   t = 0;
        int   w[N];
        int   x[N];
        exp_t e;
        for (int i = 0; i < N; i++) begin
            s8_cfg_we = 1'b1;
            s8_cfg_addr = 4'(i);
            s8_cfg_data = wdata;
            w[i] = wval;
            x[i] = 15;
            tick();
        end
        s8_cfg_we = 1'b0;
        e = model(w, x, 1, 8);
        s8_start = 1'b1;
        s8_in_valid = 1'b1;
        s8_in_data = 4'd15;
        tick();
        s8_start = 1'b0;
        while (!s8_out_valid && t < 20) begin
            tick();
            t++;
        end
        if (t == 20) check({tag, "_timeout"}, s8_out_valid, 1);
        s8_in_valid = 1'b0;
        check({tag, "_sum"}, int'($signed(s8_sum)), e.sum);
        check({tag, "_fire"}, s8_fire, e.fire);
        tick();
        check({tag, "_sum_kept"}, int'($signed(s8_sum)), e.sum);
    endtask

    // Result monitor: pops the scoreboard on handshake, checks held outputs
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev <= 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_sum", int'($signed(sum)), held_sum);
                check("hold_fire", fire, held_fire);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_depth", sb.size(), 1);
                end else begin
                    sb_head = sb.pop_front();
                    check("result_sum", int'($signed(sum)), sb_head.sum);
                    check("result_fire", fire, sb_head.fire);
                end
            end
            hold_prev <= out_valid && !out_ready;
            held_sum  <= int'($signed(sum));
            held_fire <= fire;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        shadow_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_fire", fire, 0);
        check("rst_sum", int'(sum), 0);
        check("rst_cfg_err", cfg_err, 0);
        rst_n = 1'b1;
        tick();

        // Defaults with in_valid held high: latency from start edge
        sb.push_back(model(sh_w, '{1, 1, 1, 1}, sh_thr, 12));
        start = 1'b1;
        in_valid = 1'b1;
        in_data = 4'd1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check("latency_cycle", cyc + 1, 6);

        // Back-to-back: start right after the single-cycle DONE, all-zero samples
        sb.push_back(model(sh_w, '{0, 0, 0, 0}, sh_thr, 12));
        start = 1'b1;
        in_data = 4'd0;
        tick();
        check("done_one_cycle", busy, 0);
        tick();
        start = 1'b0;
        check("restart_accepted", busy, 1);
        repeat (N) tick();
        in_valid = 1'b0;
        finish(1'b0);

        // Signed weights and a high threshold
        cfg_write(4'd0, 12'hFF8, 1'b0);
        cfg_write(4'd1, 12'h007, 1'b0);
        cfg_write(4'd2, 12'h000, 1'b0);
        cfg_write(4'd3, 12'h001, 1'b0);
        cfg_write(4'd4, 12'd50, 1'b0);
        run('{15, 15, 3, 9}, 0, 1'b0, 1'b0);

        // Config write in the start cycle commits before the evaluation
        cfg_we = 1'b1;
        cfg_addr = 4'd4;
        cfg_data = 12'hFF6;
        start = 1'b1;
        tick();
        cfg_we = 1'b0;
        start = 1'b0;
        check("start_cfg_no_err", cfg_err, 0);
        shadow_write(4'd4, 12'hFF6);
        sb.push_back(model(sh_w, '{15, 15, 3, 9}, sh_thr, 12));
        feed('{15, 15, 3, 9}, 0, 1'b0);
        finish(1'b0);

        // Input gaps with start poked while busy, then held result
        run('{2, 5, 7, 1}, 3, 1'b1, 1'b1);

        // Dropped writes: while busy, and to unmapped addresses
        sb.push_back(model(sh_w, '{4, 9, 6, 12}, sh_thr, 12));
        start_eval();
        cfg_write(4'd0, 12'h003, 1'b1);
        feed('{4, 9, 6, 12}, 0, 1'b0);
        finish(1'b0);
        cfg_write(4'd15, 12'h005, 1'b1);
        cfg_write(4'd5, 12'h005, 1'b1);
        run('{4, 9, 6, 12}, 1, 1'b0, 1'b0);

        // Reset in the middle of accumulation
        start_eval();
        in_valid = 1'b1;
        in_data = 4'd9;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_sum", int'(sum), 0);
        check("abort_fire", fire, 0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        shadow_reset();
        tick();
        run('{3, 1, 2, 0}, 0, 1'b0, 1'b0);

        // Saturation on an 8-bit accumulator, both directions
        sat_run(8'h07, 7, "sat_pos");
        sat_run(8'hF8, -8, "sat_neg");

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
